mvm_ctrl: RTL and testbench

Sequencing controller for the matrix-vector multiplier. It accepts one input stream: matrix A row-major, then vector x. It writes A into NUM_LANES row-interleaved banks and x into a vector memory. It then runs NROWS/NUM_LANES compute passes, each driving NUM_LANES MAC lanes over NCOLS products, and hands each pass's results to the output stream one lane at a time. Data moves directly between the stream, memories and MAC datapath; this block generates only addresses, enables and handshakes.

---
 rtl/mvm_ctrl.sv | 115 +++++++++++
 tb/tb_mvm_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_ctrl.sv
// mvm_ctrl: matrix-vector multiply sequencer (loads A then x, runs lane passes, streams results); `define MVM_CTRL_REUSE_A_EN adds reuse_a to keep A across vectors
module mvm_ctrl #(
  parameter int NROWS = 4,
  parameter int NCOLS = 4,
  parameter int NUM_LANES = 2,
  localparam int AW = $clog2(NROWS * NCOLS / NUM_LANES) > 1 ? $clog2(NROWS * NCOLS / NUM_LANES) : 1,
  localparam int XW = $clog2(NCOLS) > 1 ? $clog2(NCOLS) : 1,
  localparam int LW = $clog2(NUM_LANES) > 1 ? $clog2(NUM_LANES) : 1,
  localparam int RW = $clog2(NROWS) > 1 ? $clog2(NROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef MVM_CTRL_REUSE_A_EN
  input  logic                 reuse_a,
`endif
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [NUM_LANES-1:0] wr_en_a,
  output logic [AW-1:0]        addr_a,
  output logic                 wr_en_x,
  output logic [XW-1:0]        addr_x,
  output logic                 clear_acc,
  output logic                 en_acc,
  output logic [LW-1:0]        out_sel,
  output logic [RW-1:0]        out_row
);
  localparam int PASSES = NROWS / NUM_LANES;
  localparam int PW = $clog2(PASSES) > 1 ? $clog2(PASSES) : 1;
  localparam logic [XW-1:0] C_LAST = XW'(NCOLS - 1);
  localparam logic [LW-1:0] L_LAST = LW'(NUM_LANES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PASSES - 1);
  typedef enum logic [2:0] {LOAD_A, LOAD_X, COMPUTE, DRAIN, OUTPUT} state_t;
  state_t state, wrap_state;
  logic [XW-1:0] c;
  logic [LW-1:0] sel;
  logic [PW-1:0] pass;
  logic en_q, clr_q, last_col, last_sel, last_pass;
  assign last_col = c == C_LAST;
  assign last_sel = sel == L_LAST;
  assign last_pass = pass == P_LAST;
`ifdef MVM_CTRL_REUSE_A_EN
  assign wrap_state = reuse_a ? LOAD_X : LOAD_A;
`else
  assign wrap_state = LOAD_A;
`endif
  // LOAD_A reuses pass/sel as row-group/lane so bank address matches the compute read
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD_A;
      c <= '0;
      sel <= '0;
      pass <= '0;
      en_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      en_q <= state == COMPUTE;
      clr_q <= state == COMPUTE && c == '0;
      case (state)
        LOAD_A: if (s_valid) begin
          c <= last_col ? '0 : c + 1'b1;
          if (last_col) begin
            sel <= last_sel ? '0 : sel + 1'b1;
            if (last_sel) begin
              pass <= last_pass ? '0 : pass + 1'b1;
              if (last_pass) state <= LOAD_X;
            end
          end
        end
        LOAD_X: if (s_valid) begin
          c <= last_col ? '0 : c + 1'b1;
          if (last_col) state <= COMPUTE;
        end
        COMPUTE: begin
          c <= last_col ? '0 : c + 1'b1;
          if (last_col) state <= DRAIN;
        end
        DRAIN: state <= OUTPUT;
        OUTPUT: if (m_ready) begin
          sel <= last_sel ? '0 : sel + 1'b1;
          if (last_sel) begin
            pass <= last_pass ? '0 : pass + 1'b1;
            state <= last_pass ? wrap_state : COMPUTE;
          end
        end
        default: state <= LOAD_A;
      endcase
    end
  end
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    wr_en_a = '0;
    addr_a = '0;
    wr_en_x = 1'b0;
    addr_x = '0;
    clear_acc = 1'b0;
    en_acc = 1'b0;
    out_sel = '0;
    out_row = '0;
    if (!reset) begin
      s_ready = state == LOAD_A || state == LOAD_X;
      wr_en_a = (state == LOAD_A && s_valid) ? NUM_LANES'(1) << sel : '0;
      addr_a = (state == LOAD_A || state == COMPUTE) ? AW'(pass) * AW'(NCOLS) + AW'(c) : '0;
      wr_en_x = state == LOAD_X && s_valid;
      addr_x = (state == LOAD_X || state == COMPUTE) ? c : '0;
      clear_acc = clr_q;
      en_acc = en_q;
      m_valid = state == OUTPUT;
      out_sel = state == OUTPUT ? sel : '0;
      out_row = state == OUTPUT ? RW'(pass) * RW'(NUM_LANES) + RW'(sel) : '0;
    end
  end
endmodule

// File: tb/tb_mvm_ctrl.sv
// tb_mvm_ctrl: scoreboard bench for mvm_ctrl with behavioural banks, x memory and MAC lanes
module tb_mvm_ctrl;
  logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, m_ready = 1'b0;
  logic s_ready, m_valid, wr_en_x, clear_acc, en_acc, out_sel;
  logic [1:0] wr_en_a, addr_x, out_row;
  logic [2:0] addr_a;
  logic [14:0] all_out;
`ifdef MVM_CTRL_REUSE_A_EN
  logic reuse_a = 1'b0;
`endif
  int s_data = 0;
  int bank[2][8];
  int mem_x[4];
  int rd_a[2];
  int rd_x;
  int acc[2];
  int a_mat[16];
  int x_vec[4];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  typedef struct {logic [1:0] wa; logic [2:0] aa; logic wx; logic [1:0] ax;} wr_t;
  typedef struct {int y; int row;} out_t;
  wr_t wr_q[$];
  out_t out_q[$];

  mvm_ctrl dut (
    .clk(clk), .reset(reset),
`ifdef MVM_CTRL_REUSE_A_EN
    .reuse_a(reuse_a),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .wr_en_a(wr_en_a), .addr_a(addr_a), .wr_en_x(wr_en_x), .addr_x(addr_x),
    .clear_acc(clear_acc), .en_acc(en_acc), .out_sel(out_sel), .out_row(out_row)
  );

  assign all_out = {s_ready, m_valid, wr_en_a, addr_a, wr_en_x, addr_x, clear_acc, en_acc, out_sel, out_row};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // memories with one-cycle read latency feeding two MAC lanes
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (wr_en_a[l]) bank[l][addr_a] <= s_data;
      rd_a[l] <= bank[l][addr_a];
      if (en_acc) acc[l] <= clear_acc ? rd_a[l] * rd_x : acc[l] + rd_a[l] * rd_x;
    end
    if (wr_en_x) mem_x[addr_x] <= s_data;
    rd_x <= mem_x[addr_x];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_outputs;
    for (int r = 0; r < 4; r++) begin
      out_t e;
      e.y = 0;
      for (int c = 0; c < 4; c++) e.y += a_mat[r * 4 + c] * x_vec[c];
      e.row = r;
      out_q.push_back(e);
    end
  endtask

  task automatic do_load(input bit bubbles, input bit x_only);
    int idx, first, writes, rdy, budget;
    bit tog;
    wr_t e;
    idx = x_only ? 16 : 0;
    first = idx;
    writes = 0;
    rdy = 0;
    budget = 0;
    tog = 1'b1;
    while (idx < 20 && budget < 200) begin
      tick();
      s_valid = bubbles ? tog : 1'b1;
      tog = ~tog;
      s_data = idx < 16 ? a_mat[idx] : x_vec[idx - 16];
      #1;
      if (s_ready) rdy++;
      if (s_valid && s_ready) begin
        e.wa = idx < 16 ? 2'(1 << ((idx / 4) % 2)) : 2'b00;
        e.aa = idx < 16 ? 3'(((idx / 4) / 2) * 4 + idx % 4) : 3'd0;
        e.wx = idx >= 16;
        e.ax = idx >= 16 ? 2'(idx - 16) : 2'd0;
        wr_q.push_back(e);
        idx++;
      end
      if (wr_en_a != 2'b00 || wr_en_x) begin
        writes++;
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_bad++;
          $display("FAIL load_write: unexpected write wr_en_a=%b wr_en_x=%b", wr_en_a, wr_en_x);
        end else begin
          e = wr_q.pop_front();
          if ({wr_en_a, addr_a, wr_en_x, addr_x} !== {e.wa, e.aa, e.wx, e.ax}) begin
            n_bad++;
            $display("FAIL load_write: got wa=%b aa=%0d wx=%b ax=%0d expected wa=%b aa=%0d wx=%b ax=%0d",
                     wr_en_a, addr_a, wr_en_x, addr_x, e.wa, e.aa, e.wx, e.ax);
          end
        end
      end
      budget++;
    end
    tick();
    s_valid = 1'b0;
    #1;
    n_cmp++;
    if (idx != 20) begin n_bad++; $display("FAIL load_done: transfers %0d expected 20", idx); end
    n_cmp++;
    if (writes != 20 - first) begin n_bad++; $display("FAIL load_writes: got %0d expected %0d", writes, 20 - first); end
    n_cmp++;
    if (s_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_drop: s_ready=%b expected 0", s_ready); end
    n_cmp++;
    if (wr_q.size() != 0) begin n_bad++; $display("FAIL load_pending: %0d writes missing expected 0", wr_q.size()); end
    if (!bubbles) begin
      n_cmp++;
      if (rdy != 20 - first) begin n_bad++; $display("FAIL load_ready_cycles: got %0d expected %0d", rdy, 20 - first); end
    end
    push_outputs();
  endtask

  task automatic run_passes(input int hold, input bit rst_mid);
    int hs, budget, t1, hold_left, rel;
    bit hold_on, chk_next;
    out_t e;
    hs = 0;
    budget = 0;
    t1 = -1;
    hold_left = hold;
    hold_on = 1'b0;
    chk_next = 1'b0;
    while (hs < 4 && budget < 300) begin
      tick();
      m_ready = !(hold_left > 0 && (m_valid || hold_on));
      #1;
      if (chk_next) begin
        n_cmp++;
        if (out_sel !== 1'b1) begin n_bad++; $display("FAIL backpressure_release: out_sel=%b expected 1", out_sel); end
        chk_next = 1'b0;
      end
      if (!m_ready) begin
        hold_on = 1'b1;
        hold_left--;
        n_cmp++;
        if (m_valid !== 1'b1 || out_sel !== 1'b0) begin
          n_bad++;
          $display("FAIL backpressure_hold: m_valid=%b out_sel=%b expected 1 0", m_valid, out_sel);
        end
      end
      if (t1 >= 0 && cyc >= t1 && cyc <= t1 + 5) begin
        rel = cyc - t1;
        n_cmp++;
        if (addr_a !== 3'(rel < 4 ? 4 + rel : 0) || en_acc !== (rel >= 1 && rel <= 4) ||
            clear_acc !== (rel == 1) || m_valid !== (rel == 5) || (rel == 5 && out_row !== 2'd2)) begin
          n_bad++;
          $display("FAIL pass1_timing T+%0d: addr_a=%0d en=%b clr=%b m_valid=%b out_row=%0d", rel, addr_a, en_acc, clear_acc, m_valid, out_row);
        end
        if (rst_mid && rel == 2) return;
      end
      if (m_valid && m_ready) begin
        hs++;
        n_cmp++;
        if (out_q.size() == 0) begin
          n_bad++;
          $display("FAIL output: unexpected output row %0d", out_row);
        end else begin
          e = out_q.pop_front();
          if (acc[out_sel] !== e.y || out_row !== 2'(e.row)) begin
            n_bad++;
            $display("FAIL output: got y=%0d row=%0d expected y=%0d row=%0d", acc[out_sel], out_row, e.y, e.row);
          end
        end
        if (hs == 2) t1 = cyc + 1;
        if (hs == 1 && hold_on) chk_next = 1'b1;
      end
      budget++;
    end
    n_cmp++;
    if (hs != 4) begin n_bad++; $display("FAIL handshakes: got %0d expected 4", hs); end
    tick();
    m_ready = 1'b0;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reload_ready: s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    repeat (2) begin
      tick();
      #1;
      n_cmp++;
      if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", all_out); end
    end
    tick();
    reset = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1 || wr_en_a !== 2'b00 || addr_a !== 3'd0 || m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: s_ready=%b wr_en_a=%b addr_a=%0d m_valid=%b expected 1 00 0 0", s_ready, wr_en_a, addr_a, m_valid);
    end
  endtask

  task automatic test_identity_run;
    for (int k = 0; k < 16; k++) a_mat[k] = (k / 4 == k % 4) ? 1 : 0;
    for (int c = 0; c < 4; c++) x_vec[c] = 5 + c;
    do_load(1'b0, 1'b0);
    run_passes(0, 1'b0);
  endtask

  task automatic test_bubbles_backpressure;
    for (int k = 0; k < 16; k++) a_mat[k] = k + 1;
    for (int c = 0; c < 4; c++) x_vec[c] = c + 1;
    do_load(1'b1, 1'b0);
    run_passes(10, 1'b0);
  endtask

  task automatic test_reset_mid_pass;
    for (int k = 0; k < 16; k++) a_mat[k] = int'($urandom_range(0, 9));
    for (int c = 0; c < 4; c++) x_vec[c] = int'($urandom_range(0, 9));
    do_load(1'b0, 1'b0);
    run_passes(0, 1'b1);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (all_out !== '0) begin n_bad++; $display("FAIL reset_mid_outputs: got %h expected 0", all_out); end
    tick();
    #1;
    n_cmp++;
    if (all_out !== '0) begin n_bad++; $display("FAIL reset_mid_held: got %h expected 0", all_out); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1 || addr_a !== 3'd0 || out_row !== 2'd0 || en_acc !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_restart: s_ready=%b addr_a=%0d out_row=%0d en_acc=%b expected 1 0 0 0", s_ready, addr_a, out_row, en_acc);
    end
    wr_q.delete();
    out_q.delete();
    do_load(1'b0, 1'b0);
    run_passes(0, 1'b0);
  endtask

`ifdef MVM_CTRL_REUSE_A_EN
  task automatic test_reuse_a;
    for (int k = 0; k < 16; k++) a_mat[k] = (k % 3) + 1;
    for (int c = 0; c < 4; c++) x_vec[c] = 2 * c + 1;
    reuse_a = 1'b1;
    do_load(1'b0, 1'b0);
    run_passes(0, 1'b0);
    for (int c = 0; c < 4; c++) x_vec[c] = 9 - c;
    do_load(1'b0, 1'b1);
    reuse_a = 1'b0;
    run_passes(0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_identity_run();
    test_bubbles_backpressure();
    test_reset_mid_pass();
`ifdef MVM_CTRL_REUSE_A_EN
    test_reuse_a();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
